// File: rtl/glb_load_pkg.sv
// glb_load_pkg: shared types for the GLB load DMA (bank ids, descriptor, FSM state)
package glb_load_pkg;
  localparam int DESC_AW = 16;
  typedef enum logic [1:0] {IFMAP = 2'd0, FILTER = 2'd1, BIAS = 2'd2, PSUM = 2'd3} data_t;
  typedef struct packed {
    data_t dtype;
    logic [DESC_AW-1:0] base_addr;
    logic [DESC_AW:0] num_words;
  } load_desc_t;
  typedef enum logic [1:0] {S_IDLE, S_CHECK, S_LOAD, S_DRAIN} state_t;
endpackage

// File: rtl/glb_load_cmd_fifo.sv
// glb_load_cmd_fifo: descriptor queue with registered full/empty
// ports: push/din in, pop/dout out (dout = head), full/empty flags, flush empties the queue
module glb_load_cmd_fifo import glb_load_pkg::*; #(
  parameter int CMD_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flush,
  input  logic       push,
  input  load_desc_t din,
  input  logic       pop,
  output load_desc_t dout,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(CMD_DEPTH);
  logic [AW-1:0] wp, rp;
  logic [AW:0] cnt, cnt_n;
  logic do_push, do_pop;
  load_desc_t mem [CMD_DEPTH];
  assign do_push = push && !full && !flush;
  assign do_pop = pop && !empty && !flush;
  assign cnt_n = cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n || flush) begin
      wp <= '0;
      rp <= '0;
      cnt <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wp <= wp + AW'(do_push);
      rp <= rp + AW'(do_pop);
      cnt <= cnt_n;
      full <= cnt_n == (AW+1)'(CMD_DEPTH);
      empty <= cnt_n == '0;
    end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
endmodule

// File: rtl/glb_load_dma.sv
// glb_load_dma: descriptor-driven loader from the DRAM word stream into one of the GLB banks
// cmd_*: descriptor push (type, base word address, word count); din_*: DRAM stream
// glb_*: one-hot bank write request held until that bank's wready; abort flushes everything
// busy: work pending; done/err: one-cycle completion / rejection pulses
module glb_load_dma import glb_load_pkg::*; #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = DESC_AW,
  parameter int NUM_TYPES = 4,
  parameter int CMD_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_type,
  input  logic [ADDR_WIDTH-1:0] cmd_base_addr,
  input  logic [ADDR_WIDTH:0]   cmd_num_words,
  input  logic                  din_valid,
  output logic                  din_ready,
  input  logic [DATA_WIDTH-1:0] din_data,
  output logic [NUM_TYPES-1:0]  glb_we,
  input  logic [NUM_TYPES-1:0]  glb_wready,
  output logic [ADDR_WIDTH-1:0] glb_waddr,
  output logic [DATA_WIDTH-1:0] glb_wdata,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);
  localparam logic [ADDR_WIDTH+1:0] ADDR_SPAN = {2'b01, {ADDR_WIDTH{1'b0}}};
  state_t state, state_n;
  load_desc_t head, push_desc;
  logic empty, full, pop, accept, fire, last, oob, out_valid;
  data_t cur_type;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH:0] remaining;
  assign push_desc = '{dtype: data_t'(cmd_type), base_addr: cmd_base_addr, num_words: cmd_num_words};
  assign cmd_ready = !full;
  assign accept = din_valid && din_ready;
  assign fire = out_valid && glb_wready[cur_type];
  assign last = remaining == (ADDR_WIDTH+1)'(1);
  // widened so a range ending exactly at the top of the bank is still legal
  assign oob = ({2'b00, cur_addr} + {1'b0, remaining}) > ADDR_SPAN;
  glb_load_cmd_fifo #(.CMD_DEPTH(CMD_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(abort),
    .push(cmd_valid && cmd_ready),
    .din(push_desc),
    .pop(pop),
    .dout(head),
    .full(full),
    .empty(empty)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= state_n;
  always_comb
    state_n = abort ? S_IDLE :
              state == S_IDLE ? (empty ? S_IDLE : S_CHECK) :
              state == S_CHECK ? ((remaining == '0 || oob) ? S_IDLE : S_LOAD) :
              state == S_LOAD ? ((accept && last) ? S_DRAIN : S_LOAD) :
              (fire ? S_IDLE : S_DRAIN);
  always_comb begin
    pop = !abort && state == S_IDLE && !empty;
    din_ready = !abort && state == S_LOAD && (!out_valid || glb_wready[cur_type]);
    busy = state != S_IDLE || !empty;
    glb_we = out_valid ? NUM_TYPES'(1) << cur_type : '0;
  end
  // done/err are registered, so they appear in the IDLE cycle that pops the next descriptor
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cur_type <= IFMAP;
      cur_addr <= '0;
      remaining <= '0;
      out_valid <= 1'b0;
      glb_waddr <= '0;
      glb_wdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
    end else begin
      done <= !abort && ((state == S_CHECK && remaining == '0) || (state == S_DRAIN && fire));
      err <= !abort && state == S_CHECK && remaining != '0 && oob;
      if (pop) begin
        cur_type <= head.dtype;
        cur_addr <= head.base_addr;
        remaining <= head.num_words;
      end
      if (accept) begin
        glb_waddr <= cur_addr;
        glb_wdata <= din_data;
        cur_addr <= cur_addr + ADDR_WIDTH'(1);
        remaining <= remaining - (ADDR_WIDTH+1)'(1);
      end
      out_valid <= abort ? 1'b0 : accept ? 1'b1 : fire ? 1'b0 : out_valid;
    end
endmodule

// File: tb/tb_glb_load_dma.sv
// tb_glb_load_dma: directed tests against a descriptor-level model of expected GLB writes
module tb_glb_load_dma;
  import glb_load_pkg::*;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cmd_valid, cmd_ready, din_valid, din_ready, abort, busy, done, err;
  logic [1:0] cmd_type;
  logic [15:0] cmd_base_addr, glb_waddr;
  logic [16:0] cmd_num_words;
  logic [63:0] din_data, glb_wdata;
  logic [3:0] glb_we, glb_wready;
  typedef struct {int bank; int addr;} wr_t;
  wr_t exp_q[$];
  wr_t mon_e;
  int checks = 0, failures = 0;
  int exp_done = 0, exp_err = 0, n_done = 0, n_err = 0, n_wr = 0;
  int din_k = 0, wr_skip = 0, cyc = 0, last_wr_cyc = 0, done_cyc = 0;
  logic held_v = 1'b0, mon_fire;
  logic [83:0] held;
  always #5 clk = ~clk;
  glb_load_dma dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_base_addr(cmd_base_addr), .cmd_num_words(cmd_num_words),
    .din_valid(din_valid), .din_ready(din_ready), .din_data(din_data),
    .glb_we(glb_we), .glb_wready(glb_wready), .glb_waddr(glb_waddr), .glb_wdata(glb_wdata),
    .abort(abort), .busy(busy), .done(done), .err(err)
  );
  function automatic logic [63:0] pat(input int k);
    return 64'h0123_4567_89AB_CDEF ^ {4{k[15:0]}};
  endfunction
  assign din_data = pat(din_k);
  always @(posedge clk)
    if (rst_n && din_valid && din_ready) din_k <= din_k + 1;
  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // model: a legal descriptor expands into its ordered list of (bank, addr) writes and one done
  function automatic void add_desc(input int t, input int b, input int n);
    if (n == 0) exp_done++;
    else if (b + n > 65536) exp_err++;
    else begin
      for (int i = 0; i < n; i++) exp_q.push_back('{t, b + i});
      exp_done++;
    end
  endfunction
  always @(negedge clk)
    if (rst_n) begin
      cyc++;
      chk("we_onehot", 96'($onehot0(glb_we)), 96'd1);
      if (done) begin n_done++; done_cyc = cyc; end
      if (err) n_err++;
      if (held_v) chk("stall_hold", {glb_we, glb_waddr, glb_wdata}, held);
      mon_fire = |(glb_we & glb_wready);
      held_v = |glb_we && !mon_fire && !abort;
      held = {glb_we, glb_waddr, glb_wdata};
      if (mon_fire) begin
        if (exp_q.size() == 0) chk("unexpected_write", {glb_we, glb_waddr, glb_wdata}, '0);
        else begin
          mon_e = exp_q.pop_front();
          chk("write", {glb_we, glb_waddr, glb_wdata},
              {4'(1 << mon_e.bank), 16'(mon_e.addr), pat(n_wr + wr_skip)});
        end
        n_wr++;
        last_wr_cyc = cyc;
      end
    end
  task automatic push(input int t, input int b, input int n);
    int k = 0;
    logic acc;
    cmd_type = 2'(t);
    cmd_base_addr = 16'(b);
    cmd_num_words = 17'(n);
    cmd_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk);
      #1;
      k++;
    end while (!acc && k < 100);
    cmd_valid = 1'b0;
    chk("push_accepted", acc, 1);
    if (acc) add_desc(t, b, n);
  endtask
  task automatic wait_idle(input string name);
    int i = 0;
    while (busy && i < 500) begin
      @(posedge clk);
      #1;
      i++;
    end
    chk({name, "_idle"}, busy, 0);
    repeat (2) @(posedge clk);
    #1;
    chk({name, "_done_cnt"}, n_done, exp_done);
    chk({name, "_err_cnt"}, n_err, exp_err);
    chk({name, "_pending"}, exp_q.size(), 0);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int d0, w0, e0, acc_n;
    logic a;
    cmd_valid = 0; cmd_type = 0; cmd_base_addr = 0; cmd_num_words = 0;
    din_valid = 0; glb_wready = 0; abort = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_we", glb_we, 0);
    chk("rst_din_ready", din_ready, 0);
    chk("rst_done_err", {done, err}, 0);
    rst_n = 1;
    @(posedge clk);
    #1;
    // FILTER base 0, 4 words, free-flowing
    din_valid = 1; glb_wready = 4'hF;
    d0 = n_done; w0 = n_wr;
    push(1, 0, 4);
    wait_idle("t1");
    chk("t1_writes", n_wr - w0, 4);
    chk("t1_done", n_done - d0, 1);
    chk("t1_done_lat", done_cyc - last_wr_cyc, 1);
    // BIAS base 0x10, 3 words, bank 2 stalls on word 1
    d0 = n_done; w0 = n_wr;
    push(2, 16'h10, 3);
    for (int i = 0; i < 50 && n_wr != w0 + 1; i++) @(posedge clk);
    chk("t2_first_write", n_wr - w0, 1);
    #1 glb_wready = 4'b1011;
    repeat (2) begin
      @(negedge clk);
      chk("t2_stall_din_ready", din_ready, 0);
      chk("t2_stall_addr", glb_waddr, 16'h0011);
      chk("t2_stall_we", glb_we, 4'b0100);
    end
    @(posedge clk);
    #1 glb_wready = 4'hF;
    wait_idle("t2");
    chk("t2_writes", n_wr - w0, 3);
    chk("t2_done", n_done - d0, 1);
    // three queued descriptors
    d0 = n_done;
    push(1, 0, 2);
    push(2, 0, 1);
    push(0, 5, 2);
    wait_idle("t3");
    chk("t3_done", n_done - d0, 3);
    // illegal, empty and exactly-at-top descriptors
    d0 = n_done; w0 = n_wr; e0 = n_err;
    push(0, 16'hFFFE, 3);
    push(0, 16'h0123, 0);
    push(1, 16'hFFFE, 2);
    wait_idle("t4");
    chk("t4_err", n_err - e0, 1);
    chk("t4_done", n_done - d0, 2);
    chk("t4_writes", n_wr - w0, 2);
    // queue fills while LOAD is starved
    din_valid = 0; w0 = n_wr;
    push(1, 16'h20, 1);
    repeat (3) @(posedge clk);
    #1;
    acc_n = 0;
    for (int c = 0; c < 10; c++) begin
      cmd_valid = acc_n < 5;
      cmd_type = 2'd2; cmd_base_addr = 16'(16'h40 + acc_n); cmd_num_words = 17'd1;
      @(negedge clk);
      a = cmd_valid && cmd_ready;
      @(posedge clk);
      #1;
      if (a) begin add_desc(2, 16'h40 + acc_n, 1); acc_n++; end
    end
    cmd_valid = 0;
    chk("t5_accepted", acc_n, 4);
    chk("t5_cmd_ready", cmd_ready, 0);
    din_valid = 1;
    wait_idle("t5");
    chk("t5_writes", n_wr - w0, 5);
    // abort after 2 of 8 IFMAP words with 2 more queued
    d0 = n_done; w0 = n_wr; e0 = n_err;
    push(0, 16'h100, 8);
    push(3, 0, 2);
    push(2, 3, 1);
    for (int i = 0; i < 50 && n_wr != w0 + 2; i++) @(posedge clk);
    chk("t6_two_writes", n_wr - w0, 2);
    #1;
    abort = 1; glb_wready = 0;
    cmd_valid = 1; cmd_type = 2'd1; cmd_base_addr = 16'h50; cmd_num_words = 17'd1;
    exp_q.delete();
    exp_done = exp_done - 3;
    @(negedge clk);
    chk("t6_abort_din_ready", din_ready, 0);
    @(posedge clk);
    #1;
    abort = 0; cmd_valid = 0; glb_wready = 4'hF;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_we", glb_we, 0);
    wr_skip = din_k - n_wr;
    repeat (20) @(posedge clk);
    #1;
    chk("t6_writes", n_wr - w0, 2);
    chk("t6_no_done", n_done - d0, 0);
    chk("t6_no_err", n_err - e0, 0);
    chk("t6_idle", busy, 0);
    // reset in the middle of a transfer
    din_valid = 0;
    push(0, 0, 4);
    repeat (3) @(posedge clk);
    chk("t7_pre_busy", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("t7_busy", busy, 0);
    chk("t7_cmd_ready", cmd_ready, 1);
    chk("t7_we", glb_we, 0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk);
    #1;
    chk("t7_idle", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
